uart_cmd_responder: RTL and testbench

- Command responder on the FPGA_modulo side of the main-to-module UART link.
- Takes bytes from a uart_rx instance, decodes ON/OFF/TOGGLE commands, drives the module output-enable and emits a one-cycle sync pulse.
- Echoes every accepted command byte back through a uart_tx instance so the main FPGA can verify the link.
- A link watchdog forces the output off when the main FPGA goes silent.

---
 rtl/uart_cmd_responder.sv | 126 ++++++++++++
 tb/tb_uart_cmd_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: decodes ON/OFF/TOGGLE bytes from uart_rx, drives the module enable,
// echoes each command (or NACK) through uart_tx, and drops the output when the link goes quiet.
module uart_cmd_responder #(
    parameter logic [7:0] CMD_ON     = 8'hEE,
    parameter logic [7:0] CMD_OFF    = 8'h55,
    parameter logic [7:0] CMD_TOGGLE = 8'hC3,
    parameter logic [7:0] NACK       = 8'hFF,
    parameter int         WDT_CYCLES = 48000000,
    parameter int         ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_received,
    input  logic             rx_done,
    input  logic             parity_error,
    input  logic             tx_busy,
    output logic [7:0]       data_to_tx,
    output logic             start_tx,
    output logic             out_enable,
    output logic             sync_pulse,
    output logic             link_ok,
    output logic [ERR_W-1:0] parity_err_cnt,
    output logic [ERR_W-1:0] overrun_cnt
);
    localparam int WDT_W = ($clog2(WDT_CYCLES) > 26) ? $clog2(WDT_CYCLES) : 26;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] WAIT_TX   = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [7:0]       byte_q, byte_d, data_q, data_d;
    logic             en_q, en_d, sync_q, sync_d, link_q, link_d, seen_q, seen_d;
    logic [1:0]       to_q, to_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic [ERR_W-1:0] perr_q, perr_d, ovr_q, ovr_d;
    logic             valid, expire;

    assign valid  = byte_q == CMD_ON || byte_q == CMD_OFF || byte_q == CMD_TOGGLE;
    assign expire = wdt_q == WDT_W'(WDT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        byte_d  = byte_q;
        data_d  = data_q;
        sync_d  = 1'b0;
        seen_d  = seen_q;
        to_d    = to_q;
        perr_d  = perr_q;
        ovr_d   = (rx_done && state_q != IDLE) ? ovr_q + {{(ERR_W-1){1'b0}}, ~&ovr_q} : ovr_q;
        // Watchdog runs only while the link is up; DECODE below overrides it on a valid command
        wdt_d   = (link_q && !expire) ? wdt_q + 1'b1 : '0;
        link_d  = link_q && !expire;
        en_d    = (link_q && expire) ? 1'b0 : en_q;
        case (state_q)
            IDLE: begin
                if (rx_done && parity_error) perr_d = perr_q + {{(ERR_W-1){1'b0}}, ~&perr_q};
                if (rx_done && !parity_error) begin
                    byte_d  = data_received;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = WAIT_TX;
                data_d  = valid ? byte_q : NACK;
                if (valid) begin
                    en_d   = byte_q == CMD_ON ? 1'b1 : byte_q == CMD_OFF ? 1'b0 : ~en_q;
                    sync_d = 1'b1;
                    link_d = 1'b1;
                    wdt_d  = '0;
                end
            end
            WAIT_TX: state_d = tx_busy ? WAIT_TX : SEND;
            SEND: begin
                state_d = WAIT_DONE;
                seen_d  = 1'b0;
                to_d    = '0;
            end
            WAIT_DONE: begin
                // Give up after 4 cycles if uart_tx never acknowledges with busy
                if (seen_q) state_d = tx_busy ? WAIT_DONE : IDLE;
                else if (tx_busy) seen_d = 1'b1;
                else if (to_q == 2'd3) state_d = IDLE;
                else to_d = to_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            byte_q  <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            sync_q  <= 1'b0;
            link_q  <= 1'b0;
            seen_q  <= 1'b0;
            to_q    <= '0;
            wdt_q   <= '0;
            perr_q  <= '0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
            en_q    <= en_d;
            sync_q  <= sync_d;
            link_q  <= link_d;
            seen_q  <= seen_d;
            to_q    <= to_d;
            wdt_q   <= wdt_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_to_tx     = data_q;
    assign start_tx       = state_q == SEND;
    assign out_enable     = en_q;
    assign sync_pulse     = sync_q;
    assign link_ok        = link_q;
    assign parity_err_cnt = perr_q;
    assign overrun_cnt    = ovr_q;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: table-driven command checks plus watchdog, overrun, parity and reset
// sequences; echoes are scoreboarded against a queue filled when each command is sent.
module tb_uart_cmd_responder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_received = 8'h00;
    logic       rx_done = 1'b0;
    logic       parity_error = 1'b0;
    logic       tx_busy;
    logic [7:0] data_to_tx;
    logic       start_tx, out_enable, sync_pulse, link_ok;
    logic [7:0] parity_err_cnt, overrun_cnt;

    logic       busy_force = 1'b0;
    int         busy_cnt = 0;
    int         total = 0;
    int         bad = 0;
    int         start_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] b;
        logic       en;
        logic       sync;
        logic [7:0] echo;
    } vec_t;
    vec_t tbl[9];

    uart_cmd_responder #(.WDT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .data_received(data_received), .rx_done(rx_done),
        .parity_error(parity_error), .tx_busy(tx_busy), .data_to_tx(data_to_tx),
        .start_tx(start_tx), .out_enable(out_enable), .sync_pulse(sync_pulse),
        .link_ok(link_ok), .parity_err_cnt(parity_err_cnt), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy for 10 cycles after each start request
    assign tx_busy = busy_force || busy_cnt != 0;
    always @(posedge clk) begin
        if (start_tx) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (start_tx) begin
            start_cnt++;
            if (exp_q.size() == 0) chk("unexpected_start_tx", 1, 0);
            else chk("echo_byte", data_to_tx, exp_q.pop_front());
        end
    end

    task automatic send(input logic [7:0] b, input logic par);
        @(negedge clk);
        data_received = b;
        parity_error  = par;
        rx_done       = 1'b1;
        @(negedge clk);
        rx_done       = 1'b0;
        parity_error  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("echo_drained", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        n = 0;
        while (tx_busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("tx_released", tx_busy, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int sc;
        tbl[0] = '{8'hEE, 1'b1, 1'b1, 8'hEE};
        tbl[1] = '{8'hC3, 1'b0, 1'b1, 8'hC3};
        tbl[2] = '{8'hC3, 1'b1, 1'b1, 8'hC3};
        tbl[3] = '{8'hC3, 1'b0, 1'b1, 8'hC3};
        tbl[4] = '{8'hA7, 1'b0, 1'b0, 8'hFF};
        tbl[5] = '{8'h55, 1'b0, 1'b1, 8'h55};
        tbl[6] = '{8'hEE, 1'b1, 1'b1, 8'hEE};
        tbl[7] = '{8'hA7, 1'b1, 1'b0, 8'hFF};
        tbl[8] = '{8'h55, 1'b0, 1'b1, 8'h55};

        repeat (3) @(negedge clk);
        chk("rst_data_to_tx", data_to_tx, 0);
        chk("rst_start_tx", start_tx, 0);
        chk("rst_out_enable", out_enable, 0);
        chk("rst_sync", sync_pulse, 0);
        chk("rst_link", link_ok, 0);
        chk("rst_perr", parity_err_cnt, 0);
        chk("rst_ovr", overrun_cnt, 0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(tbl[i].echo);
            send(tbl[i].b, 1'b0);
            @(negedge clk);
            chk("vec_sync", sync_pulse, tbl[i].sync);
            chk("vec_en", out_enable, tbl[i].en);
            chk("vec_link", link_ok, 1);
            @(negedge clk);
            chk("vec_sync_low", sync_pulse, 0);
            drain();
        end

        send(8'hEE, 1'b1);
        repeat (3) @(negedge clk);
        chk("perr_one", parity_err_cnt, 1);
        chk("perr_en_off", out_enable, 0);
        for (int i = 0; i < 299; i++) send(8'hEE, 1'b1);
        @(negedge clk);
        chk("perr_sat", parity_err_cnt, 255);
        chk("ovr_zero", overrun_cnt, 0);
        chk("link_lost", link_ok, 0);

        exp_q.push_back(8'hC3);
        send(8'hC3, 1'b0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk("relink_link", link_ok, 1);
                chk("relink_toggle_en", out_enable, 1);
                chk("relink_sync", sync_pulse, 1);
            end
        end while (link_ok && k < 200);
        chk("wdt_expiry_cycle", k, 101);
        chk("wdt_en_off", out_enable, 0);
        chk("wdt_no_sync", sync_pulse, 0);
        drain();

        busy_force = 1'b1;
        exp_q.push_back(8'hEE);
        send(8'hEE, 1'b0);
        @(negedge clk);
        chk("ovr_first_en", out_enable, 1);
        send(8'h55, 1'b0);
        @(negedge clk);
        chk("ovr_one", overrun_cnt, 1);
        chk("ovr_en_kept", out_enable, 1);
        send(8'h55, 1'b1);
        @(negedge clk);
        chk("ovr_parity_byte", overrun_cnt, 2);
        chk("ovr_perr_kept", parity_err_cnt, 255);
        busy_force = 1'b0;
        drain();
        chk("ovr_en_after", out_enable, 1);

        exp_q.push_back(8'hEE);
        send(8'hEE, 1'b0);
        drain();
        exp_q.push_back(8'hEE);
        send(8'hEE, 1'b0);
        repeat (99) @(negedge clk);
        chk("pre_collision_link", link_ok, 1);
        exp_q.push_back(8'hEE);
        send(8'hEE, 1'b0);
        @(negedge clk);
        chk("collision_link", link_ok, 1);
        chk("collision_en", out_enable, 1);
        chk("collision_sync", sync_pulse, 1);
        drain();

        busy_force = 1'b1;
        send(8'hEE, 1'b0);
        @(negedge clk);
        sc = start_cnt;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_en", out_enable, 0);
        chk("mid_rst_link", link_ok, 0);
        chk("mid_rst_data", data_to_tx, 0);
        chk("mid_rst_ovr", overrun_cnt, 0);
        chk("mid_rst_perr", parity_err_cnt, 0);
        reset = 1'b1;
        busy_force = 1'b0;
        repeat (30) @(negedge clk);
        chk("no_start_after_rst", start_cnt, sc);
        chk("post_rst_start_tx", start_tx, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
